// File: rtl/tt_main.sv
// Two-digit BCD up/down counter with programmable tick prescaler, parallel load
// and 7-segment display of the selected digit; wrap flag drives the decimal point.
module tt_main #(
  parameter int SHIFT = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PW = 4 + SHIFT;

  logic [PW-1:0] presc_q, presc_d, limit;
  logic [3:0]    ones_q, ones_d, tens_q, tens_d;
  logic          wrap_q, wrap_d;
  logic          tick;

  logic       run, dir, load, sel;
  logic [3:0] rate;

  assign run  = ui_in[0];
  assign dir  = ui_in[1];
  assign load = ui_in[2];
  assign sel  = ui_in[3];
  assign rate = ui_in[7:4];

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Rate 15 overflows the PW-bit product to zero, so the -1 lands on all-ones as intended.
  always_comb begin
    limit = ((PW'(rate) + PW'(1)) << SHIFT) - PW'(1);
  end

  always_comb begin
    presc_d = presc_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    wrap_d  = wrap_q;
    tick    = 1'b0;
    if (load) begin
      ones_d  = clamp_bcd(uio_in[3:0]);
      tens_d  = clamp_bcd(uio_in[7:4]);
      presc_d = '0;
    end else if (run) begin
      // >= rather than == so a rate decrease below the current count still ticks.
      if (presc_q >= limit) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (tick) begin
        if (!dir) begin
          if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            if (tens_q == 4'd9) begin
              tens_d = 4'd0;
              wrap_d = ~wrap_q;
            end else begin
              tens_d = tens_q + 4'd1;
            end
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end else begin
          if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            if (tens_q == 4'd0) begin
              tens_d = 4'd9;
              wrap_d = ~wrap_q;
            end else begin
              tens_d = tens_q - 4'd1;
            end
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end
      end
    end
  end

  // State register: the harness pin rst_n is an active-high reset here.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      presc_q <= '0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      wrap_q  <= 1'b0;
    end else if (ena) begin
      presc_q <= presc_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      wrap_q  <= wrap_d;
    end
  end

  assign uo_out  = {wrap_q, seg_decode(sel ? tens_q : ones_q)};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_main.sv
// Directed bench for tt_main (SHIFT=0): reset, counting, rate, load, wrap and freeze.
module tb_tt_main;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  tt_main #(.SHIFT(0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
  endtask

  // Peek the tens digit by briefly flipping display select; no edge passes.
  task automatic check_tens(input string tag, input logic [7:0] exp);
    logic [7:0] save;
    save  = ui_in;
    ui_in = ui_in | 8'h08;
    #1;
    check(tag, uo_out, exp);
    ui_in = save;
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Async reset before any clock edge.
    #2;
    rst_n = 1'b1;
    #1;
    check("reset_uo_out", uo_out, 8'h3F);
    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    step(2);
    rst_n = 1'b0;

    // Basic count at rate 0: one tick per edge.
    ena   = 1'b1;
    ui_in = 8'h01;
    step(1);
    check("count_1", uo_out, 8'h06);
    step(9);
    check("count_10_ones", uo_out, 8'h3F);
    check_tens("count_10_tens", 8'h06);

    // Rate select 3: tick every 4 edges.
    ui_in = 8'h00;
    pulse_reset();
    ui_in = 8'h31;
    step(11);
    check("rate_11", uo_out, 8'h5B);
    step(1);
    check("rate_12", uo_out, 8'h4F);
    check_tens("rate_12_tens", 8'h3F);

    // Load 98, then count up through 99 to 00 with wrap.
    ui_in  = 8'h04;
    uio_in = 8'h98;
    step(1);
    ui_in = 8'h00;
    #1;
    check("load98_ones", uo_out, 8'h7F);
    check_tens("load98_tens", 8'h6F);
    ui_in = 8'h01;
    step(1);
    check("up_99", uo_out, 8'h6F);
    step(1);
    check("up_wrap_00", uo_out, 8'hBF);
    check_tens("up_wrap_tens", 8'hBF);

    // Out-of-range nibbles clamp to 9; flag stays set.
    ui_in  = 8'h04;
    uio_in = 8'hAF;
    step(1);
    ui_in = 8'h00;
    #1;
    check("clamp_ones", uo_out, 8'hEF);
    check_tens("clamp_tens", 8'hEF);

    // Down wrap 00 -> 99 toggles the flag back, then 98.
    ui_in  = 8'h04;
    uio_in = 8'h00;
    step(1);
    ui_in = 8'h00;
    #1;
    check("load00_keeps_flag", uo_out, 8'hBF);
    ui_in = 8'h03;
    step(1);
    check("down_wrap_99", uo_out, 8'h6F);
    check_tens("down_wrap_tens", 8'h6F);
    step(1);
    check("down_98", uo_out, 8'h7F);

    // Freeze: prescaler at 2 of limit 3, hold 20 edges with ena=0.
    ui_in = 8'h00;
    pulse_reset();
    ui_in = 8'h31;
    step(2);
    ena = 1'b0;
    step(20);
    check("freeze_hold", uo_out, 8'h3F);
    ena = 1'b1;
    step(1);
    check("resume_no_tick", uo_out, 8'h3F);
    step(1);
    check("resume_tick", uo_out, 8'h06);

    // Prescaler above a lowered limit ticks on the next edge.
    step(3);
    check("before_rate_drop", uo_out, 8'h06);
    ui_in = 8'h11;
    step(1);
    check("rate_drop_tick", uo_out, 8'h5B);

    // Run=0 holds digits.
    ui_in = 8'h00;
    step(5);
    check("run_off_hold", uo_out, 8'h5B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
